switch_debounce_tick: RTL

//  Conditions a raw, asynchronous, bouncing switch/button input for the lab datapath.
//  - Synchronises the input with a 2-flop synchroniser.
//  - Filters it with a stable-time counter FSM.
//  - Produces a clean level plus one-cycle rise/fall ticks.

---
 rtl/switch_debounce_tick.sv | 104 ++++++++++
 1 files changed

// File: rtl/switch_debounce_tick.sv
// Switch conditioner: 2-flop synchroniser, stable-time qualification FSM,
// registered debounced level and one-cycle rise/fall ticks.
module switch_debounce_tick #(
   parameter int STABLE_CYCLES = 1000,
   parameter int CNT_W         = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw,
   output logic db_level,
   output logic rise_tick,
   output logic fall_tick
);

   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT1 = 2'b01,
      ONE   = 2'b11,
      WAIT0 = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1, s2;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             rise_nxt, fall_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs; blocking here would collapse s1/s2 into one stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= sw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ZERO;
         cnt       <= '0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rise_tick <= rise_nxt;
         fall_tick <= fall_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      unique case (state)
         ZERO: begin
            if (s2) begin
               state_nxt = WAIT1;
               cnt_nxt   = '0;
            end
         end
         WAIT1: begin
            if (!s2) begin
               state_nxt = ZERO;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ONE;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ONE: begin
            if (!s2) begin
               state_nxt = WAIT0;
               cnt_nxt   = '0;
            end
         end
         WAIT0: begin
            if (s2) begin
               state_nxt = ONE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ZERO;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ZERO;
         end
      endcase
   end

   // Level is high while accepted-one, including while qualifying a release.
   assign db_level = (state == ONE) || (state == WAIT0);

endmodule
